// File: rtl/reg_file_multiport.sv
// Multiport general-purpose register file with byte-enabled writes, write->read forwarding,
// hardwired register 0 and a pending-write scoreboard shared between decode and writeback.
module reg_file_multiport #(
    parameter int WORDSIZE = 64,
    parameter int SIZE     = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_READ = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         write_en,
    input  logic [ADDR_W-1:0]            write_addr,
    input  logic [WORDSIZE-1:0]          write_data,
    input  logic [WORDSIZE/8-1:0]        write_be,
    input  logic [NUM_READ*ADDR_W-1:0]   rd_addr,
    output logic [NUM_READ*WORDSIZE-1:0] rd_data,
    output logic [NUM_READ-1:0]          rd_busy,
    input  logic                         pend_set,
    input  logic [ADDR_W-1:0]            pend_addr,
    output logic [SIZE-1:0]              pend_mask
);

    localparam int NB = WORDSIZE / 8;
    localparam logic [ADDR_W:0] SIZE_W = SIZE[ADDR_W:0];

    logic [WORDSIZE-1:0] regs_r [SIZE];
    logic [SIZE-1:0]     pend_r;
    logic [SIZE-1:0]     pend_next_s;
    logic                wr_ok_s;
    logic                pend_ok_s;
    logic [ADDR_W-1:0]   ra_s;

    // Replace the bytes selected by be, keep the others.
    function automatic logic [WORDSIZE-1:0] byte_merge(
        input logic [WORDSIZE-1:0] old_v,
        input logic [WORDSIZE-1:0] new_v,
        input logic [NB-1:0]       be
    );
        logic [WORDSIZE-1:0] res;
        res = old_v;
        for (int k = 0; k < NB; k++) begin
            if (be[k]) begin
                res[8*k +: 8] = new_v[8*k +: 8];
            end else begin
                res[8*k +: 8] = old_v[8*k +: 8];
            end
        end
        return res;
    endfunction

    function automatic logic addr_live(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < SIZE_W) && !((ZERO_REG != 0) && (a == {ADDR_W{1'b0}}));
    endfunction

    // Qualify write and pending-set requests; reset discards both.
    always_comb begin
        wr_ok_s   = write_en && !reset && addr_live(write_addr);
        pend_ok_s = pend_set && !reset && addr_live(pend_addr);
    end

    // Register array: sync clear, byte-merged write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < SIZE; r++) begin
                regs_r[r] <= {WORDSIZE{1'b0}};
            end
        end else if (wr_ok_s) begin
            regs_r[write_addr] <= byte_merge(regs_r[write_addr], write_data, write_be);
        end
    end

    // Scoreboard next state: writeback clears, a fresh producer set takes priority.
    always_comb begin
        pend_next_s = pend_r;
        if (wr_ok_s) begin
            pend_next_s[write_addr] = 1'b0;
        end else begin
            pend_next_s = pend_next_s;
        end
        if (pend_ok_s) begin
            pend_next_s[pend_addr] = 1'b1;
        end else begin
            pend_next_s = pend_next_s;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_r <= {SIZE{1'b0}};
        end else begin
            pend_r <= pend_next_s;
        end
    end

    assign pend_mask = pend_r;

    // Read ports with optional same-cycle forwarding of the write in flight.
    always_comb begin
        rd_data = {(NUM_READ*WORDSIZE){1'b0}};
        rd_busy = {NUM_READ{1'b0}};
        ra_s    = {ADDR_W{1'b0}};
        for (int i = 0; i < NUM_READ; i++) begin
            ra_s = rd_addr[i*ADDR_W +: ADDR_W];
            if (!addr_live(ra_s)) begin
                rd_data[i*WORDSIZE +: WORDSIZE] = {WORDSIZE{1'b0}};
                rd_busy[i]                      = 1'b0;
            end else if ((BYPASS != 0) && wr_ok_s && (ra_s == write_addr)) begin
                rd_data[i*WORDSIZE +: WORDSIZE] = byte_merge(regs_r[ra_s], write_data, write_be);
                rd_busy[i]                      = 1'b0;
            end else begin
                rd_data[i*WORDSIZE +: WORDSIZE] = regs_r[ra_s];
                rd_busy[i]                      = pend_r[ra_s];
            end
        end
    end

endmodule
